// File: rtl/pru1_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear registers and a shared blink timer.
// Channels whose blink_en bit is set are gated by the timer phase; data_out itself is never altered.
module pru1_pio_blink #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [PRESCALE_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      blink_en_q, blink_en_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] counter_q, counter_d;
    logic                  phase_q, phase_d;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = writedata[WIDTH-1:0];
                ADDR_BLINK_EN: blink_en_d = writedata[WIDTH-1:0];
                ADDR_PERIOD:   period_d   = writedata[PRESCALE_W-1:0];
                ADDR_OUTSET:   data_d     = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d     = data_q & ~writedata[WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    // A PERIOD write restarts the timer and wins over a coincident terminal count.
    always_comb begin
        counter_d = counter_q;
        phase_d   = phase_q;
        if (wr_en && (address == ADDR_PERIOD)) begin
            counter_d = '0;
            phase_d   = 1'b1;
        end else if (period_q == '0) begin
            counter_d = '0;
            phase_d   = 1'b1;
        end else if (counter_q == period_q) begin
            counter_d = '0;
            phase_d   = ~phase_q;
        end else begin
            counter_d = counter_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
            counter_q  <= '0;
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            counter_q  <= counter_d;
            phase_q    <= phase_d;
        end
    end

    // Decoded from address alone so the bus sees a defined value even when not selected.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]      = blink_en_q;
            ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[PRESCALE_W-1:0] = counter_q;
                readdata[31]             = phase_q;
            end
            default:       ;
        endcase
    end

    assign out_port = data_q & ~(blink_en_q & {WIDTH{~phase_q}});

endmodule

// File: tb/tb_pru1_pio_blink.sv
// Bench for pru1_pio_blink: directed register/blink scenarios plus random bus traffic,
// checked every cycle against a timeline-based reference model through an expected queue.
module tb_pru1_pio_blink;

    localparam int         WIDTH      = 8;
    localparam logic [7:0] RST_VAL    = 8'hA5;
    localparam int         PRESCALE_W = 24;
    localparam int         EW         = 1 + WIDTH + 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_err    = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model: registers plus the number of cycles since the timer was last restarted.
    logic [7:0]  m_data;
    logic [7:0]  m_blink;
    logic [23:0] m_period;
    longint      m_elapsed;

    pru1_pio_blink #(
        .WIDTH(WIDTH), .RESET_VALUE(RST_VAL), .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_phase();
        if (m_period == 0) return 1'b1;
        return ((m_elapsed / (longint'(m_period) + 1)) % 2) == 0;
    endfunction

    function automatic logic [23:0] m_counter();
        if (m_period == 0) return 24'd0;
        return 24'(m_elapsed % (longint'(m_period) + 1));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd1: return {24'd0, m_blink};
            3'd2: return {8'd0, m_period};
            3'd3: return {m_phase(), 7'd0, m_counter()};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] m_out();
        logic [7:0] o;
        for (int i = 0; i < WIDTH; i++)
            o[i] = m_blink[i] ? (m_data[i] & m_phase()) : m_data[i];
        return o;
    endfunction

    task automatic m_reset();
        m_data = RST_VAL; m_blink = '0; m_period = '0; m_elapsed = 0;
    endtask

    // One bus cycle: drive at negedge, queue the expected view, then advance the model at posedge.
    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        logic rd_chk;
        @(negedge clk);
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        rd_chk = cs & wn;
        exp_q.push_back({rd_chk, m_out(), m_read(a)});
        @(posedge clk);
        if (cs && !wn && a == 3'd2) begin
            m_period = wd[23:0];
            m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_blink = wd[7:0];
                3'd4: m_data = m_data | wd[7:0];
                3'd5: m_data = m_data & ~wd[7:0];
                default: ;
            endcase
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d); cycle(1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [2:0] a); cycle(1'b1, 1'b1, a, 32'd0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 3'd0, 32'd0); endtask

    // Monitor: DUT outputs are compared mid-cycle, after inputs settle and before the next edge.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_port", {24'd0, out_port}, {24'd0, e[39:32]});
                if (e[40]) check("readdata", readdata, e[31:0]);
            end
        end
    end

    initial begin
        int guard;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state readback.
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3);

        // DATA / OUTSET / OUTCLEAR, then write-only registers read as zero.
        wr(3'd0, 32'h0000_000F);
        wr(3'd4, 32'h0000_00F0);
        wr(3'd5, 32'h0000_003C);
        rd(3'd4); rd(3'd5); rd(3'd0);

        // Single-channel blink with period 3.
        wr(3'd0, 32'h0000_00FF);
        wr(3'd1, 32'h0000_0001);
        wr(3'd2, 32'd3);
        for (int i = 0; i < 14; i++) rd((i % 2 == 0) ? 3'd3 : 3'd0);

        // Period 0 stops blinking.
        wr(3'd2, 32'd0);
        rd(3'd3); idle(5); rd(3'd3);

        // Reserved and status addresses ignore writes.
        wr(3'd3, 32'hFFFF_FFFF); wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd6); rd(3'd7); rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3);

        // Asynchronous reset mid-blink at phase 0, counter 2.
        wr(3'd2, 32'd3);
        guard = 0;
        while (!(m_phase() == 1'b0 && m_counter() == 24'd2) && guard < 50) begin
            rd(3'd3);
            guard++;
        end
        check("blink_reach_timeout", guard, (guard < 50) ? guard : 0);
        @(negedge clk);
        #3;
        chipselect = 1'b1; write_n = 1'b1; address = 3'd3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'd0, out_port}, {24'd0, RST_VAL});
        check("async_rst_status", readdata, 32'h8000_0000);
        reset_n = 1'b1;
        m_reset();
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3);

        // Random traffic with short periods so blinking is exercised.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd2) d = {8'($urandom_range(0, 255)), 24'($urandom_range(0, 5))};
            case ($urandom_range(0, 7))
                0, 1:    cycle(1'b1, 1'b0, a, d);
                2:       cycle(1'b0, 1'($urandom_range(0, 1)), a, d);
                default: cycle(1'b1, 1'b1, a, d);
            endcase
        end
        idle(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        check("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
